pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and address width in bits (>=8).
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset (XLEN bits, word-aligned).
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (>=2).
REQ-004 SHALL have port clk, input, 1, clock, rising-edge active.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, advance/update permitted this cycle; low = stall.
REQ-007 SHALL have port trap_valid, input, 1, load trap vector this cycle.
REQ-008 SHALL have port trap_vector, input, XLEN, trap target; bits[1:0] ignored (treated as 0).
REQ-009 SHALL have port redirect_valid, input, 1, branch/jump taken.
REQ-010 SHALL have port redirect_target, input, XLEN, branch/jump target.
REQ-011 SHALL have port call_valid, input, 1, current instruction is a call; push pc+4.
REQ-012 SHALL have port ret_valid, input, 1, current instruction is a return; pop predicted target.
REQ-013 SHALL have port pc, output, XLEN, current PC (registered).
REQ-014 SHALL have port pc_plus4, output, XLEN, pc+4 modulo 2^XLEN (combinational).
REQ-015 SHALL have port misaligned_fault, output, 1, registered one-cycle pulse: rejected redirect.
REQ-016 SHALL have port ras_empty, output, 1, RAS count = 0.
REQ-017 SHALL have port ras_full, output, 1, RAS count = RAS_DEPTH.
REQ-018 SHALL have port ras_underflow, output, 1, registered one-cycle pulse: return on empty RAS.

Function
REQ-019 pc SHALL change only on a rising clk edge with reset=1 or enable=1.
REQ-020 With enable=1, next pc priority: trap_valid -> {trap_vector[XLEN-1:2],2'b00}; else redirect_valid -> redirect_target; else ret_valid and RAS non-empty -> RAS top; else pc_plus4.
REQ-021 pc+4 SHALL wrap from 2^XLEN-4 to 0 with no flag.
REQ-022 Redirect with redirect_target[1:0]!=0 (and no trap) SHALL leave pc unchanged and pulse misaligned_fault next cycle.
REQ-023 call_valid with enable=1 and trap_valid=0 SHALL push pc_plus4, independent of redirect_valid.
REQ-024 ret_valid with enable=1, trap_valid=0, redirect_valid=0 SHALL pop; on empty RAS, pc takes pc_plus4 and ras_underflow pulses.
REQ-025 Push on full RAS SHALL discard the oldest entry; count stays RAS_DEPTH.
REQ-026 Simultaneous effective call and pop SHALL replace top with pc_plus4, count unchanged; pc takes old top.
REQ-027 trap_valid with enable=1 SHALL clear RAS count to 0 in the same edge.
REQ-028 enable=0 SHALL freeze pc and RAS; pulse outputs deassert.
REQ-029 Latency: new pc visible exactly one cycle after the qualifying edge.

Reset
REQ-030 On reset: pc=RESET_VECTOR, RAS count=0, misaligned_fault=0, ras_underflow=0; reset overrides enable and all requests.
REQ-031 Reset mid-stall or mid-redirect SHALL discard the pending request.

Configuration
REQ-032 Macro PC_GEN_RAS_EN: defined -> RAS per REQ-023..027.
REQ-033 Undefined -> no RAS storage; call_valid/ret_valid ignored, ret falls through to pc_plus4, ras_empty=1, ras_full=0, ras_underflow=0.

Verification
REQ-034 Reset with RESET_VECTOR=0x100, then 3 cycles enable=1 -> pc 0x100,0x104,0x108,0x10C.
REQ-035 pc=0x200, enable=0 for 4 cycles with redirect to 0x400 -> pc stays 0x200; then enable=1 -> 0x400.
REQ-036 Redirect 0x302 at pc=0x10 -> pc stays 0x10, misaligned_fault=1 for one cycle; trap same cycle to 0x83 -> pc=0x80, no fault.
REQ-037 RAS_DEPTH=4: calls at 0x0,0x10,0x20,0x30,0x40 (redirect 0x1000) then 5 returns -> pc 0x44,0x34,0x24,0x14, fifth ras_underflow=1, pc=prev+4.
REQ-038 pc=0xFFFFFFFC, enable=1 -> pc=0x0; reset asserted during pending trap -> pc=RESET_VECTOR, ras_empty=1.

Source files
------------

// File: rtl/pc_gen.sv
// Program counter generator: trap/redirect/return/sequential next-PC selection with an
// optional return-address stack enabled by defining PC_GEN_RAS_EN.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call_valid,
  input  logic            ret_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned_fault,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow
);

  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] ras_top;
  logic            ret_hit;
  logic            fault_next;

  assign pc_plus4 = pc + XLEN'(4);

`ifdef PC_GEN_RAS_EN
  localparam int CW = $clog2(RAS_DEPTH + 1);

  // ras[0] is the top; older entries sit at higher indices and fall off the end
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;
  logic            ret_empty;
  logic            unused_ok;

  assign unused_ok = ^trap_vector[1:0];
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CW'(RAS_DEPTH));
  assign ras_top   = ras[0];
  assign ret_hit   = ret_valid && !ras_empty;
  assign do_push   = enable && !trap_valid && call_valid;
  assign do_pop    = enable && !trap_valid && !redirect_valid && ret_valid && !ras_empty;
  assign ret_empty = enable && !trap_valid && !redirect_valid && ret_valid && ras_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      if (trap_valid)
        count <= '0;
      else if (do_push && !do_pop && !ras_full)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && do_pop) begin
      ras[0] <= pc_plus4;
    end else if (do_push) begin
      for (int i = RAS_DEPTH - 1; i > 0; i--)
        ras[i] <= ras[i-1];
      ras[0] <= pc_plus4;
    end else if (do_pop) begin
      for (int i = 0; i < RAS_DEPTH - 1; i++)
        ras[i] <= ras[i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ras_underflow <= 1'b0;
    else
      ras_underflow <= ret_empty;
  end
`else
  logic unused_ok;

  assign unused_ok     = ^{trap_vector[1:0], call_valid, ret_valid};
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_underflow = 1'b0;
  assign ras_top       = '0;
  assign ret_hit       = 1'b0;
`endif

  // A misaligned redirect holds the current PC and raises a fault instead.
  always_comb begin
    pc_next    = pc_plus4;
    fault_next = 1'b0;
    if (trap_valid) begin
      pc_next = {trap_vector[XLEN-1:2], 2'b00};
    end else if (redirect_valid) begin
      if (redirect_target[1:0] != 2'b00) begin
        pc_next    = pc;
        fault_next = 1'b1;
      end else begin
        pc_next = redirect_target;
      end
    end else if (ret_hit) begin
      pc_next = ras_top;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc               <= RESET_VECTOR;
      misaligned_fault <= 1'b0;
    end else begin
      misaligned_fault <= enable && fault_next;
      if (enable)
        pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Randomized self-checking bench for pc_gen against a queue-based reference model;
// follows PC_GEN_RAS_EN the same way the design does.
module tb_pc_gen;
  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, enable, trap_valid, redirect_valid, call_valid, ret_valid;
  logic [31:0] trap_vector, redirect_target;
  logic [31:0] pc, pc_plus4;
  logic        misaligned_fault, ras_empty, ras_full, ras_underflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_fault, m_uf;

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .call_valid(call_valid), .ret_valid(ret_valid),
    .pc(pc), .pc_plus4(pc_plus4), .misaligned_fault(misaligned_fault),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    logic [31:0] p4, top;
    logic        popped;
    p4     = m_pc + 32'd4;
    popped = 1'b0;
    top    = '0;
    if (reset) begin
      m_pc = RV; m_ras.delete(); m_fault = 1'b0; m_uf = 1'b0;
    end else if (!enable) begin
      m_fault = 1'b0; m_uf = 1'b0;
    end else begin
      m_fault = 1'b0; m_uf = 1'b0;
      if (trap_valid) begin
        m_pc = trap_vector & ~32'h3;
        m_ras.delete();
      end else begin
`ifdef PC_GEN_RAS_EN
        if (ret_valid && !redirect_valid) begin
          if (m_ras.size() > 0) begin
            top = m_ras.pop_front();
            popped = 1'b1;
          end else begin
            m_uf = 1'b1;
          end
        end
        if (call_valid) begin
          m_ras.push_front(p4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_back());
        end
`endif
        if (redirect_valid) begin
          if (redirect_target[1:0] != 2'b00) m_fault = 1'b1;
          else m_pc = redirect_target;
        end else if (popped) begin
          m_pc = top;
        end else begin
          m_pc = p4;
        end
      end
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("misaligned_fault", {31'd0, misaligned_fault}, {31'd0, m_fault});
    check("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
    check("ras_full", {31'd0, ras_full}, {31'd0, m_ras.size() == DEPTH});
    check("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_uf});
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 0; enable = 1; trap_valid = 0; trap_vector = '0;
    redirect_valid = 0; redirect_target = '0; call_valid = 0; ret_valid = 0;
  endtask

  task automatic jump(input logic [31:0] tgt);
    idle(); redirect_valid = 1; redirect_target = tgt; tick();
  endtask

  initial begin
    idle();
    m_pc = '0; m_fault = 0; m_uf = 0;
    @(negedge clk);
    // Reset, then three sequential steps
    reset = 1; tick(); tick();
    check("reset_pc", pc, 32'h100);
    check("reset_empty", {31'd0, ras_empty}, 32'd1);
    idle();
    tick(); check("seq1", pc, 32'h104);
    tick(); check("seq2", pc, 32'h108);
    tick(); check("seq3", pc, 32'h10C);

    // Stall with a pending redirect
    jump(32'h200);
    enable = 0; redirect_valid = 1; redirect_target = 32'h400;
    for (int i = 0; i < 4; i++) begin
      tick(); check("stall_pc", pc, 32'h200);
    end
    enable = 1; tick(); check("stall_release", pc, 32'h400);

    // Misaligned redirect, then trap overriding it
    jump(32'h10);
    redirect_valid = 1; redirect_target = 32'h302;
    tick();
    check("misalign_pc", pc, 32'h10);
    check("misalign_fault", {31'd0, misaligned_fault}, 32'd1);
    trap_valid = 1; trap_vector = 32'h83;
    tick();
    check("trap_pc", pc, 32'h80);
    check("trap_nofault", {31'd0, misaligned_fault}, 32'd0);

`ifdef PC_GEN_RAS_EN
    // Five nested calls on a four-deep stack, then five returns
    jump(32'h0);
    for (int i = 0; i < 5; i++) begin
      idle(); call_valid = 1; redirect_valid = 1;
      redirect_target = (i == 4) ? 32'h1000 : 32'(i + 1) * 32'h10;
      tick();
    end
    check("ras_full_after_calls", {31'd0, ras_full}, 32'd1);
    idle(); ret_valid = 1;
    tick(); check("ret1", pc, 32'h44);
    tick(); check("ret2", pc, 32'h34);
    tick(); check("ret3", pc, 32'h24);
    tick(); check("ret4", pc, 32'h14);
    tick(); check("ret5_pc", pc, 32'h18);
    check("ret5_underflow", {31'd0, ras_underflow}, 32'd1);
    idle(); tick();
    check("underflow_pulse_end", {31'd0, ras_underflow}, 32'd0);
`endif

    // Wrap at the top of the address space, then reset over a pending trap
    jump(32'hFFFF_FFFC);
    idle(); tick(); check("wrap", pc, 32'h0);
    idle(); call_valid = 1; tick();
    trap_valid = 1; trap_vector = 32'h5000; reset = 1;
    tick();
    check("reset_over_trap", pc, 32'h100);
    check("reset_over_trap_empty", {31'd0, ras_empty}, 32'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      enable         = ($urandom_range(0, 99) < 80);
      trap_valid     = ($urandom_range(0, 99) < 4);
      trap_vector    = $urandom;
      redirect_valid = ($urandom_range(0, 99) < 15);
      redirect_target = {20'd0, 10'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) redirect_target[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) redirect_target = 32'hFFFF_FFFC;
      call_valid     = ($urandom_range(0, 99) < 25);
      ret_valid      = ($urandom_range(0, 99) < 30);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
